// File: rtl/batch_pkg.sv
// batch_pkg: shared types and default widths for the batch-inference sequencer.
//   state_e        sequencer states
//   IMG_WID_D      default image word width (legacy img_wid value)
//   PS_WID_D       default predict width (legacy PS_wid value)
//   LBL_WID_D      default label width (same as predict width)
package batch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARST,
    S_ASTART,
    S_WAIT,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_e;

  localparam int IMG_WID_D = 32;
  localparam int PS_WID_D  = 4;
  localparam int LBL_WID_D = PS_WID_D;

endpackage

// File: rtl/batch_infer_ctrl_if.sv
// batch_infer_ctrl_if: memory and accelerator bus between the sequencer and
// its surroundings.
//   src_addr/src_data       image-store ROM (combinational read)
//   lbl_addr/lbl_data       label ROM (combinational read)
//   img_wen/waddr/wdata     accelerator image SRAM write port
//   acc_rst/acc_start       accelerator control pulses
//   acc_done/acc_predict    accelerator result
// master = sequencer side, slave = memories/accelerator side.
interface batch_infer_ctrl_if #(
  parameter int IMG_WID  = 32,
  parameter int IMG_AWID = 10,
  parameter int SRC_AWID = 24,
  parameter int CNT_WID  = 14,
  parameter int PS_WID   = 4,
  parameter int LBL_WID  = 4
);
  logic [SRC_AWID-1:0] src_addr;
  logic [IMG_WID-1:0]  src_data;
  logic [CNT_WID-1:0]  lbl_addr;
  logic [LBL_WID-1:0]  lbl_data;
  logic                img_wen;
  logic [IMG_AWID-1:0] img_waddr;
  logic [IMG_WID-1:0]  img_wdata;
  logic                acc_rst;
  logic                acc_start;
  logic                acc_done;
  logic [PS_WID-1:0]   acc_predict;

  modport master (
    output src_addr, lbl_addr, img_wen, img_waddr, img_wdata, acc_rst, acc_start,
    input  src_data, lbl_data, acc_done, acc_predict
  );

  modport slave (
    input  src_addr, lbl_addr, img_wen, img_waddr, img_wdata, acc_rst, acc_start,
    output src_data, lbl_data, acc_done, acc_predict
  );
endinterface

// File: rtl/batch_infer_ctrl_sat_cnt.sv
// sat_cnt: W-bit up counter that sticks at all-ones.
//   clk, rst_n   clock, async active-low reset
//   clr          synchronous clear (wins over inc)
//   inc          count enable
//   q            count value
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      q <= '0;
    else if (clr)                    q <= '0;
    else if (inc && q != {W{1'b1}})  q <= q + 1'b1;
  end
endmodule

// File: rtl/batch_infer_ctrl.sv
// batch_infer_ctrl: on-chip batch inference sequencer. For each image it copies
// IMG_WORDS words from the image store into the accelerator SRAM, pulses the
// accelerator reset and start, waits for done under a watchdog and compares
// the prediction against the label ROM.
//   clk, rst_n            clock, async active-low reset
//   run, num_img          start a batch of num_img images (IDLE only)
//   abort                 cancel the running batch, counters hold
//   bus                   memory/accelerator bus (master side)
//   busy, done            batch in progress / one-cycle end pulse
//   img_cnt, err_cnt,
//   to_cnt                images completed, errors (mispredict + timeout),
//                         timeouts; all saturating
module batch_infer_ctrl import batch_pkg::*; #(
  parameter int IMG_WORDS = 900,
  parameter int IMG_WID   = IMG_WID_D,
  parameter int IMG_AWID  = 10,
  parameter int SRC_AWID  = 24,
  parameter int NUM_MAX   = 10000,
  parameter int CNT_WID   = 14,
  parameter int PS_WID    = PS_WID_D,
  parameter int LBL_WID   = LBL_WID_D,
  parameter int TIMEOUT   = 2000000,
  parameter int TO_WID    = 21
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               abort,
  input  logic [CNT_WID-1:0] num_img,
  batch_infer_ctrl_if.master bus,
  output logic               busy,
  output logic               done,
  output logic [CNT_WID-1:0] img_cnt,
  output logic [CNT_WID-1:0] err_cnt,
  output logic [CNT_WID-1:0] to_cnt
);
  // Word counter runs one past the last word to cover the write lag cycle.
  localparam int WW = $clog2(IMG_WORDS + 1);
  localparam logic [CNT_WID-1:0] NUM_CAP = CNT_WID'(NUM_MAX);

  state_e              state;
  logic [WW-1:0]       w;
  logic [SRC_AWID-1:0] base;
  logic [CNT_WID-1:0]  idx;
  logic [CNT_WID-1:0]  num_lat;
  logic [TO_WID-1:0]   wd;
  logic [PS_WID-1:0]   pred;

  logic kill, timeout_hit, mispred, clr_cnt;
  logic [2:0]               inc_v;
  logic [2:0][CNT_WID-1:0]  cnt_q;

  assign kill        = abort && (state != S_IDLE);
  assign timeout_hit = (state == S_WAIT) && !bus.acc_done && (wd == TO_WID'(TIMEOUT - 1));
  assign mispred     = (state == S_CHECK) && (LBL_WID'(pred) != bus.lbl_data);
  assign clr_cnt     = (state == S_IDLE) && run;

  // Counter updates are qualified by !kill so an abort freezes them.
  assign inc_v[0] = (state == S_NEXT) && !kill;
  assign inc_v[1] = (timeout_hit || mispred) && !kill;
  assign inc_v[2] = timeout_hit && !kill;

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    sat_cnt #(.W(CNT_WID)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .inc   (inc_v[i]),
      .q     (cnt_q[i])
    );
  end

  assign img_cnt = cnt_q[0];
  assign err_cnt = cnt_q[1];
  assign to_cnt  = cnt_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      w             <= '0;
      base          <= '0;
      idx           <= '0;
      num_lat       <= '0;
      wd            <= '0;
      pred          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.src_addr  <= '0;
      bus.lbl_addr  <= '0;
      bus.img_wen   <= 1'b0;
      bus.img_waddr <= '0;
      bus.img_wdata <= '0;
      bus.acc_rst   <= 1'b1;   // accelerator held in reset with us
      bus.acc_start <= 1'b0;
    end else begin
      bus.img_wen   <= 1'b0;
      bus.acc_rst   <= 1'b0;
      bus.acc_start <= 1'b0;
      done          <= 1'b0;
      if (kill) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        bus.acc_rst <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (run) begin
            busy         <= 1'b1;
            num_lat      <= (num_img > NUM_CAP) ? NUM_CAP : num_img;
            idx          <= '0;
            base         <= '0;
            w            <= '0;
            bus.src_addr <= '0;
            if (num_img == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
          // Read address leads, SRAM write follows one cycle later with the
          // registered read data.
          S_LOAD: begin
            if (w != WW'(IMG_WORDS)) begin
              bus.img_wen   <= 1'b1;
              bus.img_waddr <= IMG_AWID'(w);
              bus.img_wdata <= bus.src_data;
              bus.src_addr  <= bus.src_addr + 1'b1;
              w             <= w + 1'b1;
            end else begin
              state       <= S_ARST;
              bus.acc_rst <= 1'b1;
            end
          end
          S_ARST: begin
            state         <= S_ASTART;
            bus.acc_start <= 1'b1;
          end
          S_ASTART: begin
            state <= S_WAIT;
            wd    <= '0;
          end
          S_WAIT: begin
            if (bus.acc_done) begin
              pred         <= bus.acc_predict;
              bus.lbl_addr <= idx;
              state        <= S_CHECK;
            end else if (wd == TO_WID'(TIMEOUT - 1)) begin
              state <= S_NEXT;
            end else begin
              wd <= wd + 1'b1;
            end
          end
          S_CHECK: state <= S_NEXT;
          S_NEXT: begin
            if (idx == num_lat - 1'b1) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              idx          <= idx + 1'b1;
              base         <= base + SRC_AWID'(IMG_WORDS);
              bus.src_addr <= base + SRC_AWID'(IMG_WORDS);
              w            <= '0;
              state        <= S_LOAD;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_batch_infer_ctrl.sv
// tb_batch_infer_ctrl: directed bench with a write/result scoreboard and a
// behavioural accelerator stub (done N cycles after start, predict = low bits
// of image word 0 as written into the SRAM model).
module tb_batch_infer_ctrl;
  localparam int IW   = 4;
  localparam int TO   = 16;
  localparam int CW   = 14;
  localparam int NMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic abort = 1'b0;
  logic [CW-1:0] num_img = '0;
  logic busy, done;
  logic [CW-1:0] img_cnt, err_cnt, to_cnt;

  batch_infer_ctrl_if #(.IMG_WID(32), .IMG_AWID(10), .SRC_AWID(24), .CNT_WID(CW),
                        .PS_WID(4), .LBL_WID(4)) bus ();

  batch_infer_ctrl #(.IMG_WORDS(IW), .IMG_WID(32), .IMG_AWID(10), .SRC_AWID(24),
                     .NUM_MAX(NMAX), .CNT_WID(CW), .PS_WID(4), .LBL_WID(4),
                     .TIMEOUT(TO), .TO_WID(21)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .abort(abort), .num_img(num_img),
    .bus(bus), .busy(busy), .done(done),
    .img_cnt(img_cnt), .err_cnt(err_cnt), .to_cnt(to_cnt)
  );

  always #5 clk = ~clk;

  // ROMs
  logic [31:0] src_rom [64];
  logic [3:0]  lbl_rom [16];
  assign bus.src_data = src_rom[bus.src_addr[5:0]];
  assign bus.lbl_data = lbl_rom[bus.lbl_addr[3:0]];

  // Accelerator stub; lat_tab[i] is the done latency for the i-th start of a
  // batch, 0 = never answers.
  logic [31:0] sram [16];
  int lat_tab [8];
  int sidx = 0;
  int scnt = 0;
  assign bus.acc_predict = sram[0][3:0];

  always @(posedge clk) begin
    if (bus.img_wen) sram[bus.img_waddr[3:0]] <= bus.img_wdata;
    bus.acc_done <= 1'b0;
    if (run && !busy) sidx <= 0;
    if (bus.acc_start) begin
      sidx <= sidx + 1;
      if (lat_tab[sidx] > 0) begin
        scnt         <= lat_tab[sidx] - 1;
        bus.acc_done <= (lat_tab[sidx] == 1);
      end else begin
        scnt <= 0;
      end
    end else if (scnt > 0) begin
      scnt         <= scnt - 1;
      bus.acc_done <= (scnt == 1);
    end
  end

  // Scoreboard
  typedef struct packed { logic [9:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic [CW-1:0] i; logic [CW-1:0] e; logic [CW-1:0] t; } res_t;
  wr_t  wq [$];
  res_t rq [$];
  wr_t  wexp;
  res_t rexp;
  int nvec = 0;
  int nerr = 0;
  int nstart = 0;
  int nrst = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (bus.acc_start) nstart++;
    if (bus.acc_rst) nrst++;
    if (bus.img_wen) begin
      chk("wr_expected", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) begin
        wexp = wq.pop_front();
        chk("wr_addr", 32'(bus.img_waddr), 32'(wexp.a));
        chk("wr_data", bus.img_wdata, wexp.d);
      end
    end
    if (done) begin
      chk("done_expected", 32'(rq.size() > 0), 32'd1);
      if (rq.size() > 0) begin
        rexp = rq.pop_front();
        chk("img_cnt", 32'(img_cnt), 32'(rexp.i));
        chk("err_cnt", 32'(err_cnt), 32'(rexp.e));
        chk("to_cnt",  32'(to_cnt),  32'(rexp.t));
      end
    end
  end

  // Model: expected writes, final counters and done latency for a batch.
  task automatic launch(input int n, output int exp_cyc);
    int m;
    int e;
    int t;
    logic [3:0] p;
    m = (n > NMAX) ? NMAX : n;
    e = 0; t = 0; exp_cyc = 0;
    for (int i = 0; i < m; i++) begin
      for (int w = 0; w < IW; w++) wq.push_back('{a: 10'(w), d: src_rom[IW*i+w]});
      p = src_rom[IW*i][3:0];
      if (lat_tab[i] == 0) begin
        e++; t++;
        exp_cyc += IW + 4 + TO;          // LOAD+lag, ARST, ASTART, WAIT, NEXT
      end else begin
        if (p != lbl_rom[i]) e++;
        exp_cyc += IW + 5 + lat_tab[i];  // ... plus CHECK
      end
    end
    rq.push_back('{i: CW'(m), e: CW'(e), t: CW'(t)});
    num_img = CW'(n);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
  endtask

  // Called just after accept edge k (start = number of edges consumed since k).
  task automatic wait_done(input string tag, input int exp_cyc, input int start);
    int c;
    bit seen;
    c = start; seen = 1'b0;
    while (c < 300 && !seen) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        c++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(c), 32'(exp_cyc));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1 chk({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  int ec, s0, r0, dcount;

  initial begin
    for (int i = 0; i < 64; i++) src_rom[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0107;
    for (int i = 0; i < 16; i++) lbl_rom[i] = src_rom[IW*i][3:0];
    for (int i = 0; i < 8; i++) lat_tab[i] = 4;

    // Reset values
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wen", 32'(bus.img_wen), 32'd0);
    chk("rst_start", 32'(bus.acc_start), 32'd0);
    chk("rst_acc_rst", 32'(bus.acc_rst), 32'd1);
    chk("rst_src_addr", 32'(bus.src_addr), 32'd0);
    chk("rst_cnts", 32'(img_cnt | err_cnt | to_cnt), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single image, label matches, first write one edge after accept
    launch(1, ec);
    @(negedge clk);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_wen_k", 32'(bus.img_wen), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("s1_wen_k1", 32'(bus.img_wen), 32'd1);
    @(posedge clk);
    wait_done("s1", ec, 2);

    // 2: three images, image 1 mislabelled; run while busy is ignored
    lbl_rom[1] = lbl_rom[1] ^ 4'h3;
    launch(3, ec);
    repeat (5) @(posedge clk);
    #1 begin num_img = CW'(1); run = 1'b1; end
    @(posedge clk);
    #1 run = 1'b0;
    wait_done("s2", ec, 6);
    lbl_rom[1] = src_rom[IW][3:0];

    // 3: empty batch
    s0 = nstart; r0 = nrst;
    launch(0, ec);
    wait_done("s3", ec, 0);
    chk("s3_no_start", 32'(nstart - s0), 32'd0);
    chk("s3_no_acc_rst", 32'(nrst - r0), 32'd0);

    // 4: first image times out, second completes
    lat_tab[0] = 0;
    launch(2, ec);
    wait_done("s4", ec, 0);
    lat_tab[0] = 4;

    // 5: abort at w=2 of image 1, then restart
    launch(2, ec);
    repeat (15) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_acc_rst", 32'(bus.acc_rst), 32'd1);
    chk("s5_img_hold", 32'(img_cnt), 32'd1);
    chk("s5_err_hold", 32'(err_cnt), 32'd0);
    chk("s5_wr_left", 32'(wq.size()), 32'd2);
    wq.delete(); rq.delete();
    dcount = 0;
    repeat (20) begin @(negedge clk); if (done) dcount++; end
    chk("s5_no_done", 32'(dcount), 32'd0);
    @(posedge clk); #1;
    launch(1, ec);
    wait_done("s5r", ec, 0);

    // 6: async reset mid-WAIT, then abort and a clean run
    lat_tab[0] = 0;
    launch(1, ec);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_acc_rst", 32'(bus.acc_rst), 32'd1);
    chk("s6_start", 32'(bus.acc_start), 32'd0);
    chk("s6_wen", 32'(bus.img_wen), 32'd0);
    chk("s6_addr", 32'(bus.src_addr) | 32'(bus.lbl_addr) | 32'(bus.img_waddr), 32'd0);
    chk("s6_wdata", bus.img_wdata, 32'd0);
    chk("s6_cnts", 32'(img_cnt | err_cnt | to_cnt), 32'd0);
    wq.delete(); rq.delete();
    lat_tab[0] = 4;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    launch(1, ec);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("s6_abort_busy", 32'(busy), 32'd0);
    wq.delete(); rq.delete();
    @(posedge clk); #1;
    launch(1, ec);
    wait_done("s6r", ec, 0);

    // 7: batch size above NUM_MAX is clamped
    for (int i = 0; i < 8; i++) lat_tab[i] = 1;
    launch(9, ec);
    wait_done("s7", ec, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
